muldiv_unit: RTL

Execute-stage multiply/divide unit for the pipelined MIPS core, sitting directly downstream of the decode-to-execute control register. It consumes the E-stage operands, the multiply/divide opcode and the `hienE`/`loenE` write enables, and owns the architectural HI/LO registers. MULT/MULTU take two cycles and DIV/DIVU take 34 (iterative restoring divider). `busy` tells the hazard unit to stall.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_div_iter.sv | 23 ++
 rtl/muldiv_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared opcode/state types for the E-stage multiply/divide unit
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } mdop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } mdstate_t;

    localparam int DIV_ITERS = 32;

endpackage

// File: rtl/muldiv_div_iter.sv
// rtl/muldiv_div_iter.sv - one combinational restoring-divide step on {rem,quo}
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remNext,
    output logic [WIDTH-1:0] quoNext
);

    logic [WIDTH:0] remShift;
    logic [WIDTH:0] diff;

    // The extra top bit keeps the shifted remainder exact before the trial subtract.
    always_comb begin
        remShift = {rem, quo[WIDTH-1]};
        diff     = remShift - {1'b0, divisor};
        quoNext  = {quo[WIDTH-2:0], ~diff[WIDTH]};
        remNext  = diff[WIDTH] ? remShift[WIDTH-1:0] : diff[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - E-stage multiply/divide unit owning the HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DIV_ITERS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [1:0]       mdopE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             hienE,
    input  logic             loenE,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    mdstate_t         state, stateNext;
    mdop_t            op, opIn;
    logic [WIDTH-1:0] opA, opB;
    logic [WIDTH-1:0] rem, quo, remNext, quoNext;
    logic [WIDTH-1:0] hiReg, loReg;
    logic [WIDTH-1:0] magA, magB;
    logic [CW-1:0]    count;
    logic             quoNeg, remNeg;
    logic             isDiv, aNeg, bNeg;
    logic [2*WIDTH-1:0] extA, extB, product;

    always_comb begin
        opIn  = mdop_t'(mdopE);
        isDiv = (opIn == MD_DIV) || (opIn == MD_DIVU);
        aNeg  = (opIn == MD_DIV) && srcaE[WIDTH-1];
        bNeg  = (opIn == MD_DIV) && srcbE[WIDTH-1];
        magA  = aNeg ? -srcaE : srcaE;
        magB  = bNeg ? -srcbE : srcbE;
    end

    // Extending to 2*WIDTH makes one unsigned multiply serve both MULT and MULTU.
    always_comb begin
        extA    = {{WIDTH{(op == MD_MULT) && opA[WIDTH-1]}}, opA};
        extB    = {{WIDTH{(op == MD_MULT) && opB[WIDTH-1]}}, opB};
        product = extA * extB;
    end

    div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .rem     (rem),
        .quo     (quo),
        .divisor (opB),
        .remNext (remNext),
        .quoNext (quoNext)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (startE) stateNext = isDiv ? DIV : MUL;
            MUL:  stateNext = IDLE;
            DIV:  if (count == CW'(WIDTH - 1)) stateNext = FIX;
            FIX:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op     <= MD_MULT;
            opA    <= '0;
            opB    <= '0;
            rem    <= '0;
            quo    <= '0;
            count  <= '0;
            quoNeg <= 1'b0;
            remNeg <= 1'b0;
            hiReg  <= '0;
            loReg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hienE) hiReg <= srcaE;
                    if (loenE) loReg <= srcaE;
                    if (startE) begin
                        op    <= opIn;
                        rem   <= '0;
                        count <= '0;
                        if (isDiv) begin
                            quo    <= magA;
                            opB    <= magB;
                            quoNeg <= aNeg ^ bNeg;
                            remNeg <= aNeg;
                        end else begin
                            opA <= srcaE;
                            opB <= srcbE;
                        end
                    end
                end
                MUL: begin
                    hiReg <= product[2*WIDTH-1:WIDTH];
                    loReg <= product[WIDTH-1:0];
                end
                DIV: begin
                    rem   <= remNext;
                    quo   <= quoNext;
                    count <= count + CW'(1);
                end
                FIX: begin
                    loReg <= quoNeg ? -quo : quo;
                    hiReg <= remNeg ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign hi   = hiReg;
    assign lo   = loReg;

endmodule
